// File: rtl/spi_flash_pkg.sv
// Shared encodings for the SPI flash controller: FSM states, register map and bit positions.
package spi_flash_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } state_e;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int unsigned CTRL_CS      = 0;
  localparam int unsigned CTRL_CLR_OVR = 1;
  localparam int unsigned CTRL_RA_EN   = 2;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_VALID   = 1;
  localparam int unsigned STAT_CS      = 2;
  localparam int unsigned STAT_OVERRUN = 3;
  localparam int unsigned STAT_RA_EN   = 4;

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider: one-cycle tick every CLK_DIV cycles while running, restarted on
// transfer start.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic run_i,
  output logic tick_o
);

  localparam logic [7:0] Last = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q == Last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i && !restart_i && (cnt_q == Last);

endmodule

// File: rtl/spi_flash_ctl.sv
// Byte-wide SPI mode-0 master for the configuration flash on the j1 I/O bus.
// Optional streaming read-ahead is enabled by defining SPI_FLASH_CTL_READ_AHEAD_EN.
module spi_flash_ctl
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic        addr,
  input  logic [7:0]  wdata,
  output logic [15:0] rdata,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n,
  output logic        busy
);

  state_e     state_q, state_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       cs_q, cs_d;
  logic       ra_en_q, ra_en_d;

  logic idle, tick, start, done, data_wr, ctrl_wr, data_rd, ra_launch;
  logic unused_wdata;

  assign unused_wdata = ^wdata;

  assign idle    = (state_q == StIdle);
  assign data_wr = wr && (addr == ADDR_DATA);
  assign ctrl_wr = wr && (addr == ADDR_CTRL);
  assign data_rd = rd && (addr == ADDR_DATA);

`ifdef SPI_FLASH_CTL_READ_AHEAD_EN
  // A DATA read in idle with read-ahead armed clocks out 0xFF to fetch the next byte.
  assign ra_launch = data_rd && !wr && ra_en_q && cs_q && idle;
`else
  assign ra_launch = 1'b0;
`endif

  assign start = (data_wr && idle) || ra_launch;
  assign done  = (state_q == StHigh) && tick && (bit_cnt_q == 3'd0);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk_i    (clk),
    .rst_i    (reset),
    .restart_i(start),
    .run_i    (!idle),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLow;
      StLow:   if (tick) state_d = StHigh;
      StHigh:  if (tick) state_d = (bit_cnt_q == 3'd0) ? StIdle : StLow;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    cs_d      = cs_q;
    ra_en_d   = ra_en_q;

    if (start) begin
      tx_d      = data_wr ? wdata : 8'hFF;
      bit_cnt_d = 3'd7;
    end
    if ((state_q == StLow) && tick) begin
      rx_sh_d = {rx_sh_q[6:0], miso};
    end
    if ((state_q == StHigh) && tick && (bit_cnt_q != 3'd0)) begin
      tx_d      = {tx_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 3'd1;
    end
    if (done) begin
      rx_data_d = rx_sh_q;
    end

    // A completing byte beats a same-cycle read so it is never lost.
    if (done) begin
      valid_d = 1'b1;
    end else if (data_rd) begin
      valid_d = 1'b0;
    end

    if (wr && !idle) begin
      overrun_d = 1'b1;
    end else if (ctrl_wr) begin
      cs_d = wdata[CTRL_CS];
      if (wdata[CTRL_CLR_OVR]) overrun_d = 1'b0;
`ifdef SPI_FLASH_CTL_READ_AHEAD_EN
      ra_en_d = wdata[CTRL_RA_EN];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_q      <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cs_q      <= 1'b0;
      ra_en_q   <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cs_q      <= cs_d;
      ra_en_q   <= ra_en_d;
    end
  end

  always_comb begin
    sck  = (state_q == StHigh);
    busy = !idle;
    mosi = tx_q[7];
    cs_n = !cs_q;

    rdata = '0;
    if (addr == ADDR_DATA) begin
      rdata[7:0] = rx_data_q;
    end else begin
      rdata[STAT_BUSY]    = !idle;
      rdata[STAT_VALID]   = valid_q;
      rdata[STAT_CS]      = cs_q;
      rdata[STAT_OVERRUN] = overrun_q;
`ifdef SPI_FLASH_CTL_READ_AHEAD_EN
      rdata[STAT_RA_EN]   = ra_en_q;
`endif
    end
  end

endmodule
